// File: rtl/http_server_listen_ctrl.sv
// Listen-port sequencer for the HTTP server kernel. It turns the start level into a one-shot
// TCP listen request with bounded retry and timeout, and freezes the configuration snapshot.
module http_server_listen_ctrl #(
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        startServer,
  input  logic [15:0] serverPort,
  input  logic [63:0] fileList,
  input  logic [63:0] fileData,
  input  logic [31:0] fileNum,
  output logic        m_axis_listen_port_tvalid,
  input  logic        m_axis_listen_port_tready,
  output logic [15:0] m_axis_listen_port_tdata,
  input  logic        s_axis_listen_status_tvalid,
  output logic        s_axis_listen_status_tready,
  input  logic [7:0]  s_axis_listen_status_tdata,
  output logic        server_active,
  output logic        listen_fail,
  output logic [63:0] fileList_q,
  output logic [63:0] fileData_q,
  output logic [31:0] fileNum_q,
  output logic [3:0]  attempts
);
  // state    | meaning
  // IDLE     | waiting for a start rise
  // REQ      | listen request presented, waiting for tready
  // WAIT_STS | request accepted, waiting for a status beat or timeout
  // ACTIVE   | port open, snapshot valid
  // FAIL     | attempts exhausted or no files configured
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     MAX_ATT  = 4'(MAX_RETRY);

  logic [2:0]    state;
  logic          start_d;
  logic          start_rise;
  logic [15:0]   port_q;
  logic [TW-1:0] timer;
  logic [3:0]    attempts_q;
  logic          sts_beat;
  logic          unused_sts_bits;

  assign start_rise      = startServer & ~start_d;
  assign sts_beat        = s_axis_listen_status_tvalid;
  assign unused_sts_bits = ^s_axis_listen_status_tdata[7:1];

  // Timer is a down-counter loaded at the handshake; terminal count zero marks the timeout.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      start_d    <= 1'b0;
      port_q     <= '0;
      timer      <= '0;
      attempts_q <= '0;
      fileList_q <= '0;
      fileData_q <= '0;
      fileNum_q  <= '0;
    end else begin
      start_d <= startServer;
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            port_q     <= serverPort;
            fileList_q <= fileList;
            fileData_q <= fileData;
            fileNum_q  <= fileNum;
            attempts_q <= '0;
            state      <= (fileNum == '0) ? ST_FAIL : ST_REQ;
          end
        end
        ST_REQ: begin
          if (m_axis_listen_port_tready) begin
            attempts_q <= (attempts_q >= MAX_ATT) ? MAX_ATT : attempts_q + 4'd1;
            timer      <= TMR_LOAD;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (timer != '0) timer <= timer - TW'(1);
          if (!startServer) begin
            state <= ST_IDLE;
          end else if (sts_beat && s_axis_listen_status_tdata[0]) begin
            state <= ST_ACTIVE;
          end else if (sts_beat || timer == '0) begin
            state <= (attempts_q >= MAX_ATT) ? ST_FAIL : ST_REQ;
          end
        end
        ST_ACTIVE, ST_FAIL: begin
          if (!startServer) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_listen_port_tvalid   = (state == ST_REQ);
  assign m_axis_listen_port_tdata    = port_q;
  assign s_axis_listen_status_tready = 1'b1;
  assign server_active               = (state == ST_ACTIVE);
  assign listen_fail                 = (state == ST_FAIL);
  assign attempts                    = attempts_q;

endmodule

// File: tb/tb_http_server_listen_ctrl.sv
// Randomized and directed bench for http_server_listen_ctrl, compared every cycle
// against a transaction-level model that tracks the listen session with absolute deadlines.
module tb_http_server_listen_ctrl;
  localparam int MAXR = 3;
  localparam int TMO  = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        startServer;
  logic [15:0] serverPort;
  logic [63:0] fileList;
  logic [63:0] fileData;
  logic [31:0] fileNum;
  logic        m_axis_listen_port_tvalid;
  logic        m_axis_listen_port_tready;
  logic [15:0] m_axis_listen_port_tdata;
  logic        s_axis_listen_status_tvalid;
  logic        s_axis_listen_status_tready;
  logic [7:0]  s_axis_listen_status_tdata;
  logic        server_active;
  logic        listen_fail;
  logic [63:0] fileList_q;
  logic [63:0] fileData_q;
  logic [31:0] fileNum_q;
  logic [3:0]  attempts;

  int errors = 0;
  int checks = 0;

  http_server_listen_ctrl #(.MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .startServer(startServer), .serverPort(serverPort),
    .fileList(fileList), .fileData(fileData), .fileNum(fileNum),
    .m_axis_listen_port_tvalid(m_axis_listen_port_tvalid),
    .m_axis_listen_port_tready(m_axis_listen_port_tready),
    .m_axis_listen_port_tdata(m_axis_listen_port_tdata),
    .s_axis_listen_status_tvalid(s_axis_listen_status_tvalid),
    .s_axis_listen_status_tready(s_axis_listen_status_tready),
    .s_axis_listen_status_tdata(s_axis_listen_status_tdata),
    .server_active(server_active), .listen_fail(listen_fail),
    .fileList_q(fileList_q), .fileData_q(fileData_q), .fileNum_q(fileNum_q),
    .attempts(attempts)
  );

  always #5 ACLK = ~ACLK;

  // Session model: at most one of requesting/waiting/listening/failed is set.
  bit          m_req, m_wait, m_act, m_fail, m_sd;
  logic [15:0] m_port;
  logic [63:0] m_fl, m_fd;
  logic [31:0] m_fn;
  int          m_att, cyc, m_deadline;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_wait = 0; m_act = 0; m_fail = 0; m_sd = 0;
    m_port = '0; m_fl = '0; m_fd = '0; m_fn = '0; m_att = 0; m_deadline = 0;
  endtask

  task automatic model_step();
    bit rise, retry;
    cyc++;
    if (ARESET) begin
      model_reset();
      return;
    end
    rise = startServer && !m_sd;
    m_sd = startServer;
    retry = 0;
    if (m_req) begin
      if (m_axis_listen_port_tready) begin
        m_req = 0; m_wait = 1;
        if (m_att < MAXR) m_att++;
        m_deadline = cyc + TMO;
      end
    end else if (m_wait) begin
      if (!startServer) m_wait = 0;
      else if (s_axis_listen_status_tvalid) begin
        if (s_axis_listen_status_tdata[0]) begin m_wait = 0; m_act = 1; end
        else retry = 1;
      end else if (cyc == m_deadline) retry = 1;
      if (retry) begin
        m_wait = 0;
        if (m_att == MAXR) m_fail = 1; else m_req = 1;
      end
    end else if (m_act || m_fail) begin
      if (!startServer) begin m_act = 0; m_fail = 0; end
    end else if (rise) begin
      m_port = serverPort; m_fl = fileList; m_fd = fileData; m_fn = fileNum; m_att = 0;
      if (fileNum == 0) m_fail = 1; else m_req = 1;
    end
  endtask

  task automatic check_outputs();
    chk("tvalid", 64'(m_axis_listen_port_tvalid), 64'(m_req));
    chk("tdata", 64'(m_axis_listen_port_tdata), 64'(m_port));
    chk("sts_tready", 64'(s_axis_listen_status_tready), 64'd1);
    chk("server_active", 64'(server_active), 64'(m_act));
    chk("listen_fail", 64'(listen_fail), 64'(m_fail));
    chk("fileList_q", fileList_q, m_fl);
    chk("fileData_q", fileData_q, m_fd);
    chk("fileNum_q", 64'(fileNum_q), 64'(m_fn));
    chk("attempts", 64'(attempts), 64'(m_att));
    chk("flags_exclusive", 64'(server_active & listen_fail), 64'd0);
  endtask

  task automatic tick();
    @(posedge ACLK);
    model_step();
    @(negedge ACLK);
    check_outputs();
  endtask

  task automatic beat(input logic [7:0] d);
    s_axis_listen_status_tvalid = 1'b1;
    s_axis_listen_status_tdata  = d;
    tick();
    s_axis_listen_status_tvalid = 1'b0;
    s_axis_listen_status_tdata  = '0;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    ARESET = 1'b1; startServer = 1'b0; serverPort = 16'd80;
    fileList = 64'h1000; fileData = 64'h2000; fileNum = 32'd4;
    m_axis_listen_port_tready = 1'b1;
    s_axis_listen_status_tvalid = 1'b0; s_axis_listen_status_tdata = '0;
    tick(); tick();
    ARESET = 1'b0;
    tick();

    // Happy path
    startServer = 1'b1;
    tick();
    chk("s1_tvalid_lat1", 64'(m_axis_listen_port_tvalid), 64'd1);
    chk("s1_tdata", 64'(m_axis_listen_port_tdata), 64'h0050);
    tick(); tick(); tick();
    beat(8'h01);
    chk("s1_active", 64'(server_active), 64'd1);
    chk("s1_attempts", 64'(attempts), 64'd1);

    // Retry then success
    startServer = 1'b0; tick();
    startServer = 1'b1; tick();
    tick(); tick(); beat(8'h00);
    tick(); tick(); beat(8'h00);
    tick(); tick(); beat(8'h01);
    chk("s2_active", 64'(server_active), 64'd1);
    chk("s2_attempts", 64'(attempts), 64'd3);
    chk("s2_no_fail", 64'(listen_fail), 64'd0);

    // Timeout exhaustion, then a late success beat is drained
    startServer = 1'b0; tick();
    startServer = 1'b1; tick();
    repeat (3 * (TMO + 1) + 5) tick();
    chk("s3_fail", 64'(listen_fail), 64'd1);
    beat(8'h01);
    tick();
    chk("s3_fail_held", 64'(listen_fail), 64'd1);
    chk("s3_not_active", 64'(server_active), 64'd0);

    // Zero files
    startServer = 1'b0; tick();
    fileNum = 32'd0; startServer = 1'b1; tick();
    chk("s4_no_tvalid", 64'(m_axis_listen_port_tvalid), 64'd0);
    chk("s4_fail", 64'(listen_fail), 64'd1);
    startServer = 1'b0; tick();
    chk("s4_fail_clr", 64'(listen_fail), 64'd0);

    // Backpressure while start falls, then abort racing a success beat
    fileNum = 32'd7; serverPort = 16'h1F90; m_axis_listen_port_tready = 1'b0;
    startServer = 1'b1; tick();
    startServer = 1'b0;
    repeat (5) tick();
    chk("s5_tvalid_held", 64'(m_axis_listen_port_tvalid), 64'd1);
    chk("s5_tdata_held", 64'(m_axis_listen_port_tdata), 64'h1F90);
    m_axis_listen_port_tready = 1'b1; tick(); tick();
    startServer = 1'b1; tick(); tick(); tick();
    startServer = 1'b0; beat(8'h01);
    chk("s5_abort_inactive", 64'(server_active), 64'd0);

    // Snapshot freeze, then reset mid-request
    fileList = 64'h1234_5678_9ABC_DEF0; startServer = 1'b1; tick();
    tick(); beat(8'h01);
    fileList = 64'hDEAD; tick(); tick();
    chk("s6_snapshot_frozen", fileList_q, 64'h1234_5678_9ABC_DEF0);
    startServer = 1'b0; tick();
    m_axis_listen_port_tready = 1'b0; startServer = 1'b1; tick();
    chk("s6_req_tvalid", 64'(m_axis_listen_port_tvalid), 64'd1);
    ARESET = 1'b1; tick();
    chk("s6_rst_tvalid", 64'(m_axis_listen_port_tvalid), 64'd0);
    chk("s6_rst_flags", 64'({server_active, listen_fail}), 64'd0);
    chk("s6_rst_attempts", 64'(attempts), 64'd0);
    ARESET = 1'b0; tick();

    // Random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) startServer = ~startServer;
      m_axis_listen_port_tready   = ($urandom_range(0, 9) < 7);
      s_axis_listen_status_tvalid = ($urandom_range(0, 19) == 0);
      s_axis_listen_status_tdata  = 8'($urandom);
      serverPort = 16'($urandom);
      fileList   = {$urandom, $urandom};
      fileData   = {$urandom, $urandom};
      fileNum    = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 100));
      ARESET     = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
